// File: rtl/adder_cla_pipe_if.sv
// Operand/result handshake bundle for adder_cla_pipe.
// master drives operands and out_ready; slave is the adder.
interface adder_cla_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit slice per stage.
// Define ADDER_CLA_PIPE_OVF_EN to build the registered signed-overflow flag.
module adder_cla_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_cla_pipe_if.slave io
);
  localparam int BDIV   = (BLOCK > 0) ? BLOCK : 1;
  localparam int STAGES = WIDTH / BDIV;

  if (BLOCK < 1 || WIDTH < 1 || (WIDTH % BDIV) != 0) begin : g_bad
    $fatal(1, "adder_cla_pipe: WIDTH must be a nonzero multiple of BLOCK");
  end

  // Every carry is a flat sum of generate/propagate products: no ripple.
  function automatic logic [BLOCK:0] cla(
    input logic [BLOCK-1:0] gg,
    input logic [BLOCK-1:0] pp,
    input logic             ci
  );
    logic [BLOCK:0] c;
    logic           t;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      t = ci;
      for (int m = 0; m <= i; m++) t = t & pp[m];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = gg[j];
        for (int m = j + 1; m <= i; m++) t = t & pp[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int AW = WIDTH - k * BLOCK;
    localparam int SW = (k + 1) * BLOCK;

    logic [AW-1:0]    a_in;
    logic [AW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] s;
    logic [BLOCK:0]   c;
    logic [SW-1:0]    s_n;
    logic [SW-1:0]    s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign a_in = io.A;
      assign b_in = io.Sub ? ~io.B : io.B;
      assign c_in = io.Sub | io.Cin;
      assign v_in = io.in_valid;
      assign s_n  = s;
    end else begin : g_body
      assign a_in = g_stage[k-1].g_skew.a_q;
      assign b_in = g_stage[k-1].g_skew.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_n  = {s, g_stage[k-1].s_q};
    end

    assign g = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
    assign p = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
    assign c = cla(g, p, c_in);
    assign s = p ^ c[BLOCK-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_n;
        c_q <= c[BLOCK];
        v_q <= v_in;
      end
    end

    // Upper operand bits ride along until their slice's stage.
    if (k < STAGES - 1) begin : g_skew
      logic [AW-BLOCK-1:0] a_q;
      logic [AW-BLOCK-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[AW-1:BLOCK];
          b_q <= b_in[AW-1:BLOCK];
        end
      end
    end

`ifdef ADDER_CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c[BLOCK] ^ c[BLOCK-1];
        end
      end
    end
`endif
  end

  assign adv          = !g_stage[STAGES-1].v_q | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = g_stage[STAGES-1].v_q;
  assign io.Sum       = g_stage[STAGES-1].s_q;
  assign io.Cout      = g_stage[STAGES-1].c_q;
`ifdef ADDER_CLA_PIPE_OVF_EN
  assign io.Ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`else
  assign io.Ovf       = 1'b0;
`endif
endmodule

// File: doc/adder_cla_pipe.md
ADDER_CLA_PIPE -- requirements
Module: adder_cla_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 The block SHALL have parameter BLOCK, default 4, bits per carry-lookahead slice and per pipeline stage.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state rising-edge triggered.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand beat offered.
REQ-006 The block SHALL have port in_ready, output, 1, operand beat accepted when in_valid and in_ready both high.
REQ-007 The block SHALL have port A, input, WIDTH, operand A.
REQ-008 The block SHALL have port B, input, WIDTH, operand B.
REQ-009 The block SHALL have port Cin, input, 1, carry-in; ignored when Sub=1.
REQ-010 The block SHALL have port Sub, input, 1, 0 = A+B+Cin, 1 = A+~B+1.
REQ-011 The block SHALL have port out_valid, output, 1, result beat present.
REQ-012 The block SHALL have port out_ready, input, 1, consumer takes result when out_valid and out_ready both high.
REQ-013 The block SHALL have port Sum, output, WIDTH, result bits.
REQ-014 The block SHALL have port Cout, output, 1, carry out of MSB; in subtract mode 1 = no borrow.
REQ-015 The block SHALL have port Ovf, output, 1, signed two's-complement overflow.

Function
REQ-016 Elaboration SHALL fail if WIDTH is not a nonzero multiple of BLOCK or BLOCK < 1; STAGES = WIDTH/BLOCK.
REQ-017 Stage k (0..STAGES-1) SHALL compute slice bits [k*BLOCK +: BLOCK] with 4-bit-style lookahead generate/propagate logic (no ripple within a slice), taking carry from the stage k-1 carry register (stage 0: Cin, or 1 when Sub=1).
REQ-018 Upper operand slices SHALL be delayed through skew registers; completed lower sum slices SHALL be carried forward through deskew registers, so a full-width result emerges aligned.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input beat to out_valid with its result, absent backpressure (STAGES=1 -> 1 cycle).
REQ-020 Throughput SHALL be one beat per cycle when out_ready stays high.
REQ-021 Pipeline SHALL advance as a whole when advance = !out_valid | out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-022 When advance=0 all stage registers, valid bits and outputs SHALL hold; no beat lost, duplicated or reordered.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 on advance) SHALL propagate as invalid stages and never assert out_valid.
REQ-024 Sum/Cout/Ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; Cout = bit WIDTH of the full addition; Sub applied to B bitwise before stage 0.
REQ-026 Simultaneous output accept and input accept SHALL both occur in the same cycle.

Reset
REQ-027 On rst_n low all valid bits SHALL clear immediately (asynchronous); out_valid=0, Sum=0, Cout=0, Ovf=0.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; after release, first output appears STAGES cycles after first new accepted beat.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-030 With ADDER_CLA_PIPE_OVF_EN defined, Ovf SHALL equal carry-into-MSB XOR Cout for the result, registered with Sum.
REQ-031 Without ADDER_CLA_PIPE_OVF_EN, Ovf SHALL be tied 0 and no overflow logic or register SHALL be generated.

Verification
REQ-032 WIDTH=16,BLOCK=4: A=0xFFFF,B=0x0001,Cin=0,Sub=0 -> exactly 4 cycles later Sum=0x0000,Cout=1,Ovf=0.
REQ-033 Sub=1,A=0x0005,B=0x0007 -> Sum=0xFFFE,Cout=0; Sub=1,A=0x0007,B=0x0005 -> Sum=0x0002,Cout=1.
REQ-034 OVF_EN defined: A=0x7FFF,B=0x0001 -> Sum=0x8000,Ovf=1; undefined -> Ovf=0.
REQ-035 Stream 8 back-to-back beats (A=i,B=i*3), out_ready low cycles 3-5 -> in_ready low same cycles, all 8 results in order, none lost.
REQ-036 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately, no stale result after release.
REQ-037 WIDTH=4,BLOCK=4: A=15,B=15,Cin=0 -> 1 cycle later Sum=0xE,Cout=1.
